decoder_out_buffer: RTL and testbench
=====================================

Name: decoder_out_buffer

Overview:
- Downstream of the Viterbi traceback stage. Captures each completed traceback word of TRACEBACK_DEPTH 2-bit symbols.
- Traceback fills pair index 0 with the newest symbol, so this block reverses the word into chronological order.
- Streams one 2-bit symbol per cycle on a valid/ready interface.
- Two-slot ping-pong storage lets one frame be captured while another drains.

Parameters:
- TRACEBACK_DEPTH, 32, symbols per frame; the input word is TRACEBACK_DEPTH*2 bits; legal range 2..64.
- SYM_W, 2, bits per decoded symbol; fixed to match the traceback pair output.
- IDX_W, $clog2(TRACEBACK_DEPTH), width of the symbol index counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_decoder_data  in  TRACEBACK_DEPTH*2  traceback result; pair k = bits [2k+1:2k]; pair 0 is the newest symbol.
- i_decoder_done  in  1  level; high once the traceback word is complete; stays high until traceback is reset.
- o_frame_ack  out  1  one-cycle pulse when a frame is captured; the controller uses it to restart traceback.
- o_data  out  2  symbol output.
- o_valid  out  1  o_data is valid.
- i_ready  in  1  sink accepts o_data this cycle.
- o_last  out  1  high with the final symbol of a frame.
- o_overflow  out  1  sticky; set when a frame arrives while both slots are full.

Behaviour:
- Reset: rst low asynchronously clears both slots, slot-full flags, write/read pointers, index counter, done-edge register, FSM (to IDLE) and all outputs (o_frame_ack, o_data, o_valid, o_last, o_overflow = 0). This applies mid-stream: a partially sent frame is discarded.
- Capture:
  - Triggered on the rising edge of i_decoder_done (registered previous value low, current value high).
  - If the write slot is empty: store i_decoder_data, set its full flag, toggle the write pointer, pulse o_frame_ack in the next cycle.
  - If both slots are full: drop the frame, set o_overflow, no o_frame_ack.
  - A level held high never re-captures.
- Read FSM:
  - IDLE: if the read slot is full, go to STREAM with index = TRACEBACK_DEPTH-1. o_valid rises the cycle after the slot becomes full, so capture-to-first-valid latency is 2 cycles from the done edge.
  - STREAM: o_data = pair[index] of the read slot; o_valid = 1; o_last = (index == 0).
  - On a handshake (o_valid & i_ready) with index > 0: decrement the index.
  - On a handshake with index == 0: clear the slot's full flag and toggle the read pointer. If the other slot is already full, reload index = TRACEBACK_DEPTH-1 and stay in STREAM with no bubble; otherwise go to IDLE.
- Output stability: while o_valid is high and i_ready is low, o_data, o_last and the index hold.
- Same-cycle capture and release: a capture into slot A in the same cycle slot B is released is legal; both flags update independently. A capture into the slot being released in that cycle is treated as full and is dropped, so the full check uses registered flags.
- Symbol order: emitted oldest first, pair TRACEBACK_DEPTH-1 down to pair 0. Frame throughput is TRACEBACK_DEPTH cycles when i_ready is held high.

Optional Feature:
- Macro: OUTBUF_FRAME_CNT_EN.
- When defined: adds output ports o_frame_cnt [15:0] and o_drop_cnt [15:0].
  - o_frame_cnt increments on each o_last handshake.
  - o_drop_cnt increments on each dropped frame.
  - Both wrap from 0xFFFF to 0 and reset to 0.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (param_def.sv):
  - TRACEBACK_DEPTH and SYM_W defines.
  - Read-FSM enum typedef {IDLE, STREAM}.
  - Frame word typedef logic [TRACEBACK_DEPTH*2-1:0].
- Sub-module: outbuf_slot. One frame register plus full flag with load/clear and a symbol mux by index, instantiated twice.

Test Plan:
- Single frame, DEPTH=4, data=8'b11_10_01_00, i_ready=1 -> o_frame_ack 1 cycle after the done edge; o_data 11,10,01,00 on 4 consecutive cycles starting 2 cycles after the edge; o_last on the 4th symbol.
- Backpressure: i_ready toggles 1,0,0,1 during frame 8'hE4 -> no symbol lost or duplicated; o_data held while i_ready=0.
- Back-to-back frames 8'hE4 then 8'h1B, second captured mid-stream -> 8 contiguous valid cycles: 11,10,01,00,00,01,10,11; o_last on cycles 4 and 8.
- Overflow: i_ready=0, three done edges with data A, B, C -> A and B stored, C dropped; o_overflow=1; after draining, outputs are A then B only.
- Held i_decoder_done high for 20 cycles -> exactly one capture and one o_frame_ack.
- Reset asserted mid-stream at the 2nd symbol -> o_valid, o_last, o_overflow = 0 immediately; no further symbols until a new done edge.

Source files
------------

// File: rtl/decoder_out_buffer_pkg.sv
// Shared constants and types for the Viterbi decoder output buffer.
package decoder_out_buffer_pkg;

    localparam int DEF_TRACEBACK_DEPTH = 32;
    localparam int SYM_W               = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    typedef logic [DEF_TRACEBACK_DEPTH*SYM_W-1:0] frame_t;

endpackage

// File: rtl/decoder_out_buffer_slot.sv
// One ping-pong slot: a captured traceback word, its full flag and a symbol mux.
module decoder_out_buffer_slot
    import decoder_out_buffer_pkg::*;
#(
    parameter int  TRACEBACK_DEPTH = DEF_TRACEBACK_DEPTH,
    localparam int IDX_W           = $clog2(TRACEBACK_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               load,
    input  logic                               clr,
    input  logic [TRACEBACK_DEPTH*SYM_W-1:0]   din,
    input  logic [IDX_W-1:0]                   idx,
    output logic                               full,
    output logic [SYM_W-1:0]                   sym
);

    logic [TRACEBACK_DEPTH*SYM_W-1:0] frame_r;
    logic                             full_r;

    // Frame storage and occupancy; load and clear never target a slot together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_r <= {(TRACEBACK_DEPTH*SYM_W){1'b0}};
            full_r  <= 1'b0;
        end else if (load) begin
            frame_r <= din;
            full_r  <= 1'b1;
        end else if (clr) begin
            full_r  <= 1'b0;
        end else begin
            full_r  <= full_r;
        end
    end

    assign full = full_r;
    assign sym  = frame_r[{idx, 1'b0} +: SYM_W];

endmodule

// File: rtl/decoder_out_buffer.sv
// Captures traceback words into two ping-pong slots and streams them oldest symbol first.
// Optional OUTBUF_FRAME_CNT_EN adds delivered-frame and dropped-frame counters.
module decoder_out_buffer
    import decoder_out_buffer_pkg::*;
#(
    parameter int  TRACEBACK_DEPTH = DEF_TRACEBACK_DEPTH,
    localparam int IDX_W           = $clog2(TRACEBACK_DEPTH)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [TRACEBACK_DEPTH*SYM_W-1:0]   i_decoder_data,
    input  logic                               i_decoder_done,
    output logic                               o_frame_ack,
    output logic [SYM_W-1:0]                   o_data,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic                               o_last,
    output logic                               o_overflow
`ifdef OUTBUF_FRAME_CNT_EN
    ,
    output logic [15:0]                        o_frame_cnt,
    output logic [15:0]                        o_drop_cnt
`endif
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TRACEBACK_DEPTH - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    rd_state_e        state_r, state_nxt_s;
    logic [IDX_W-1:0] idx_r, idx_nxt_s;
    logic             rd_ptr_r, rd_ptr_nxt_s, wr_ptr_r;
    logic             done_prev_r;
    logic             ack_r, valid_r, last_r, ovf_r;
    logic [SYM_W-1:0] data_r;

    logic             done_edge_s, capture_s, drop_s, hs_s, release_s;
    logic [1:0]       load_s, clr_s, full_s;
    logic [SYM_W-1:0] sym_s [2];

    for (genvar g = 0; g < 2; g++) begin : g_slot
        decoder_out_buffer_slot #(
            .TRACEBACK_DEPTH (TRACEBACK_DEPTH)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .load (load_s[g]),
            .clr  (clr_s[g]),
            .din  (i_decoder_data),
            .idx  (idx_nxt_s),
            .full (full_s[g]),
            .sym  (sym_s[g])
        );
    end

    // Capture/drop decisions use registered full flags, so a slot freed this cycle still counts as full
    always_comb begin
        done_edge_s = i_decoder_done & ~done_prev_r;
        capture_s   = done_edge_s & ~full_s[wr_ptr_r];
        drop_s      = done_edge_s &  full_s[wr_ptr_r];
        hs_s        = valid_r & i_ready;
        release_s   = hs_s & (idx_r == IDX_ZERO);
        load_s      = {capture_s & wr_ptr_r, capture_s & ~wr_ptr_r};
        clr_s       = {release_s & rd_ptr_r, release_s & ~rd_ptr_r};
    end

    // Read FSM next state; the symbol mux is driven by the next index so outputs can be registered
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        rd_ptr_nxt_s = rd_ptr_r;
        case (state_r)
            IDLE: begin
                if (full_s[rd_ptr_r]) begin
                    state_nxt_s = STREAM;
                    idx_nxt_s   = IDX_LAST;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (hs_s && (idx_r != IDX_ZERO)) begin
                    idx_nxt_s = idx_r - IDX_ONE;
                end else if (hs_s) begin
                    rd_ptr_nxt_s = ~rd_ptr_r;
                    if (full_s[~rd_ptr_r]) begin
                        idx_nxt_s = IDX_LAST;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    idx_nxt_s = idx_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            idx_r       <= IDX_ZERO;
            rd_ptr_r    <= 1'b0;
            wr_ptr_r    <= 1'b0;
            done_prev_r <= 1'b0;
            ack_r       <= 1'b0;
            valid_r     <= 1'b0;
            last_r      <= 1'b0;
            ovf_r       <= 1'b0;
            data_r      <= {SYM_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_r ^ capture_s;
            done_prev_r <= i_decoder_done;
            ack_r       <= capture_s;
            valid_r     <= (state_nxt_s == STREAM);
            last_r      <= (state_nxt_s == STREAM) && (idx_nxt_s == IDX_ZERO);
            ovf_r       <= ovf_r | drop_s;
            data_r      <= (state_nxt_s == STREAM) ? sym_s[rd_ptr_nxt_s] : {SYM_W{1'b0}};
        end
    end

    assign o_frame_ack = ack_r;
    assign o_data      = data_r;
    assign o_valid     = valid_r;
    assign o_last      = last_r;
    assign o_overflow  = ovf_r;

`ifdef OUTBUF_FRAME_CNT_EN
    logic [15:0] frame_cnt_r, drop_cnt_r;

    // Wrapping statistics counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_cnt_r <= 16'd0;
            drop_cnt_r  <= 16'd0;
        end else begin
            frame_cnt_r <= frame_cnt_r + {15'd0, hs_s & last_r};
            drop_cnt_r  <= drop_cnt_r + {15'd0, drop_s};
        end
    end

    assign o_frame_cnt = frame_cnt_r;
    assign o_drop_cnt  = drop_cnt_r;
`endif

endmodule

// File: tb/tb_decoder_out_buffer.sv
// Self-checking bench for decoder_out_buffer against a frame-queue reference model.
module tb_decoder_out_buffer;

    localparam int D  = 4;
    localparam int DW = 2 * D;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] i_decoder_data;
    logic          i_decoder_done;
    logic          o_frame_ack;
    logic [1:0]    o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_last;
    logic          o_overflow;
`ifdef OUTBUF_FRAME_CNT_EN
    logic [15:0]   o_frame_cnt;
    logic [15:0]   o_drop_cnt;
`endif

    decoder_out_buffer #(.TRACEBACK_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_decoder_data (i_decoder_data),
        .i_decoder_done (i_decoder_done),
        .o_frame_ack    (o_frame_ack),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_last         (o_last),
        .o_overflow     (o_overflow)
`ifdef OUTBUF_FRAME_CNT_EN
        ,
        .o_frame_cnt    (o_frame_cnt),
        .o_drop_cnt     (o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: frames held in the buffer, oldest first
    logic [DW-1:0] q[$];
    int   sent      = 0;
    logic exp_ack   = 1'b0;
    logic exp_ovf   = 1'b0;
    logic prev_done = 1'b0;
    int   idle      = 0;
    int   cyc_n     = 0;
    int   first_v   = -1;
    int   last_v    = -1;
    int   v_cnt     = 0;
    int   ack_cnt   = 0;
    int   frm_done  = 0;
    int   frm_drop  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic mark();
        first_v = -1;
        last_v  = -1;
        v_cnt   = 0;
    endtask

    // One cycle: drive inputs at the falling edge, check outputs, advance the model for the next rising edge
    task automatic cyc(input logic d, input logic [DW-1:0] dat, input logic rdy);
        logic [DW-1:0] frm;
        logic [1:0]    es;
        int            occ;
        @(negedge clk);
        i_decoder_done = d;
        i_decoder_data = dat;
        i_ready        = rdy;
        cyc_n++;
        check_eq("ack", 32'(o_frame_ack), 32'(exp_ack));
        check_eq("overflow", 32'(o_overflow), 32'(exp_ovf));
        check_eq("spurious_valid", 32'(o_valid && (q.size() == 0)), 32'd0);
        if (o_valid) begin
            if (first_v < 0) first_v = cyc_n;
            last_v = cyc_n;
            v_cnt++;
        end
        if ((q.size() != 0) && !o_valid) idle++;
        else idle = 0;
        check_eq("stall", 32'(idle > 1), 32'd0);
        if (o_frame_ack) ack_cnt++;
        occ = q.size();
        if (o_valid && rdy && (q.size() != 0)) begin
            frm = q[0];
            es  = frm[2*(D-1-sent) +: 2];
            check_eq("data", 32'(o_data), 32'(es));
            check_eq("last", 32'(o_last), 32'(sent == D - 1));
            if (sent == D - 1) begin
                void'(q.pop_front());
                sent = 0;
                frm_done++;
            end else begin
                sent++;
            end
        end
        exp_ack = 1'b0;
        if (d && !prev_done) begin
            if (occ < 2) begin
                q.push_back(dat);
                exp_ack = 1'b1;
            end else begin
                exp_ovf = 1'b1;
                frm_drop++;
            end
        end
        prev_done = d;
    endtask

    task automatic model_reset();
        q.delete();
        sent      = 0;
        exp_ack   = 1'b0;
        exp_ovf   = 1'b0;
        prev_done = 1'b0;
        idle      = 0;
        frm_done  = 0;
        frm_drop  = 0;
    endtask

    int c;

    initial begin
        rst            = 1'b0;
        i_decoder_done = 1'b0;
        i_decoder_data = '0;
        i_ready        = 1'b0;
        #1;
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_last", 32'(o_last), 32'd0);
        check_eq("rst_ack", 32'(o_frame_ack), 32'd0);
        check_eq("rst_ovf", 32'(o_overflow), 32'd0);
        check_eq("rst_data", 32'(o_data), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // Single frame, 2-cycle latency, 4 contiguous symbols
        mark(); c = cyc_n + 1;
        cyc(1'b1, 8'b11_10_01_00, 1'b1);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);
        check_eq("single_first", 32'(first_v), 32'(c + 2));
        check_eq("single_last", 32'(last_v), 32'(c + 5));
        check_eq("single_cnt", 32'(v_cnt), 32'd4);

        // Backpressure 1,0,0,1 mid-frame
        mark(); c = cyc_n + 1;
        cyc(1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);
        check_eq("bp_last", 32'(last_v), 32'(c + 7));
        check_eq("bp_cnt", 32'(v_cnt), 32'd6);

        // Back-to-back frames with no bubble
        mark(); c = cyc_n + 1;
        cyc(1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h1B, 1'b1);
        repeat (10) cyc(1'b0, 8'h00, 1'b1);
        check_eq("b2b_first", 32'(first_v), 32'(c + 2));
        check_eq("b2b_last", 32'(last_v), 32'(c + 9));
        check_eq("b2b_cnt", 32'(v_cnt), 32'd8);

        // Overflow: third frame dropped while sink stalls
        mark();
        cyc(1'b1, 8'hA5, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h3C, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h96, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        check_eq("ovf_set", 32'(o_overflow), 32'd1);
        repeat (12) cyc(1'b0, 8'h00, 1'b1);
        check_eq("ovf_drained", 32'(v_cnt), 32'd12);

        // Held done level captures once
        ack_cnt = 0;
        repeat (20) cyc(1'b1, DW'($urandom), 1'b1);
        repeat (6) cyc(1'b0, 8'h00, 1'b1);
        check_eq("held_acks", 32'(ack_cnt), 32'd1);

        // Asynchronous reset at the second symbol
        cyc(1'b1, 8'hE4, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        i_decoder_done = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
        check_eq("mid_rst_last", 32'(o_last), 32'd0);
        check_eq("mid_rst_ovf", 32'(o_overflow), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        mark();
        repeat (6) cyc(1'b0, 8'h00, 1'b1);
        check_eq("post_rst_quiet", 32'(v_cnt), 32'd0);

        // Randomized traffic
        begin
            logic d;
            d = 1'b0;
            for (int i = 0; i < 800; i++) begin
                if ($urandom_range(0, 3) == 0) d = ~d;
                cyc(d, DW'($urandom), ($urandom_range(0, 9) < 7));
            end
        end
        repeat (20) cyc(1'b0, 8'h00, 1'b1);
        check_eq("drain_empty", 32'(q.size()), 32'd0);
        check_eq("drain_valid", 32'(o_valid), 32'd0);
`ifdef OUTBUF_FRAME_CNT_EN
        check_eq("frame_cnt", 32'(o_frame_cnt), 32'(frm_done));
        check_eq("drop_cnt", 32'(o_drop_cnt), 32'(frm_drop));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
